// File: rtl/error_calculator_mc.sv
// ============================================================================
// error_calculator_mc
// ----------------------------------------------------------------------------
// Multi-channel ANC error stage. Each channel (one per earbud) negates its
// microphone feedback to form the adaptive-filter error and tracks
// convergence with a hysteretic two-state FSM (ADAPT / CONVERGED). A channel
// enters CONVERGED after CONV_COUNT consecutive in-band samples and re-arms
// (returns to ADAPT) after REARM_COUNT consecutive out-of-band samples.
// While a channel is CONVERGED, or while nc_on is low, its error is forced
// to zero. The FSMs keep running regardless of nc_on.
//
// Optional feature (compile-time macro ERROR_GAIN_EN):
//   defined   : the saturated error is arithmetically right-shifted by
//               gain_shift_in, sampled on the error_ready cycle.
//   undefined : gain_shift_in is ignored; the error is the saturated
//               negation of the feedback.
//
// Ports:
//   clk_in         in   1             system clock
//   rst_in         in   1             asynchronous, active-high reset
//   feedback_in    in   NUM_CH*WIDTH  signed feedback, channel c at [c*WIDTH +: WIDTH]
//   error_ready    in   1             sample strobe, all channels valid this cycle
//   nc_on          in   1             noise-cancel enable (gates error only)
//   gain_shift_in  in   4             error right-shift amount (ERROR_GAIN_EN)
//   error_out      out  NUM_CH*WIDTH  signed error, same packing as feedback_in
//   done_out       out  1             one-cycle pulse: error_out updated
//   converged_out  out  NUM_CH        bit c = channel c is CONVERGED
// ============================================================================
module error_calculator_mc #(
    parameter int WIDTH       = 16,
    parameter int NUM_CH      = 2,
    parameter int THRESH      = 10,
    parameter int CONV_COUNT  = 256,
    parameter int REARM_COUNT = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_CH*WIDTH-1:0]   feedback_in,
    input  logic                      error_ready,
    input  logic                      nc_on,
    input  logic [3:0]                gain_shift_in,
    output logic [NUM_CH*WIDTH-1:0]   error_out,
    output logic                      done_out,
    output logic [NUM_CH-1:0]         converged_out
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int MAX_COUNT = (CONV_COUNT > REARM_COUNT) ? CONV_COUNT : REARM_COUNT;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0] CONV_LIMIT  = CNT_W'(CONV_COUNT);
    localparam logic [CNT_W-1:0] REARM_LIMIT = CNT_W'(REARM_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic signed [WIDTH-1:0] SAMPLE_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] SAMPLE_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] THRESH_POS = WIDTH'(THRESH);
    localparam logic signed [WIDTH-1:0] THRESH_NEG = WIDTH'(-THRESH);

    typedef enum logic {
        ST_ADAPT     = 1'b0,
        ST_CONVERGED = 1'b1
    } conv_state_t;

`ifndef ERROR_GAIN_EN
    // Port is kept for a uniform interface; it has no effect in this build.
    logic unused_gain_shift;
    assign unused_gain_shift = ^gain_shift_in;
`endif

    // ------------------------------------------------------------------------
    // Completion strobe: shared by all channels since they update together.
    // ------------------------------------------------------------------------
    logic done_reg;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= error_ready;
        end
    end

    assign done_out = done_reg;

    // ------------------------------------------------------------------------
    // Per-channel datapath and convergence FSM
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic signed [WIDTH-1:0] fb;
            logic signed [WIDTH-1:0] neg_fb;
            logic signed [WIDTH-1:0] scaled_fb;
            logic signed [WIDTH-1:0] error_next;
            logic signed [WIDTH-1:0] error_reg;
            logic                    in_band;
            logic [CNT_W-1:0]        in_cnt_next;
            logic [CNT_W-1:0]        out_cnt_next;
            logic [CNT_W-1:0]        in_cnt_reg;
            logic [CNT_W-1:0]        out_cnt_reg;
            conv_state_t             state_reg;

            assign fb = feedback_in[gi*WIDTH +: WIDTH];

            // Strict band: both +THRESH and -THRESH count as out-of-band.
            assign in_band = (fb > THRESH_NEG) && (fb < THRESH_POS);

            // The most negative sample has no positive counterpart; clamp it.
            assign neg_fb = (fb == SAMPLE_MIN) ? SAMPLE_MAX : -fb;

`ifdef ERROR_GAIN_EN
            // >>> by an amount >= WIDTH fills with the sign bit, giving 0 or -1.
            assign scaled_fb = neg_fb >>> gain_shift_in;
`else
            assign scaled_fb = neg_fb;
`endif

            // Error is decided from the state before this sample's update, so
            // the sample that completes convergence still emits a correction.
            assign error_next = (nc_on && (state_reg == ST_ADAPT)) ? scaled_fb : '0;

            // Saturating increments; the FSM leaves its state on reaching the
            // limit, but saturation keeps the counters well-defined anyway.
            assign in_cnt_next  = (in_cnt_reg  == CONV_LIMIT)  ? in_cnt_reg  : in_cnt_reg  + CNT_ONE;
            assign out_cnt_next = (out_cnt_reg == REARM_LIMIT) ? out_cnt_reg : out_cnt_reg + CNT_ONE;

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    state_reg   <= ST_ADAPT;
                    in_cnt_reg  <= '0;
                    out_cnt_reg <= '0;
                    error_reg   <= '0;
                end else if (error_ready) begin
                    error_reg <= error_next;
                    case (state_reg)
                        ST_ADAPT: begin
                            if (in_band) begin
                                in_cnt_reg <= in_cnt_next;
                                if (in_cnt_next == CONV_LIMIT) begin
                                    state_reg   <= ST_CONVERGED;
                                    out_cnt_reg <= '0;
                                end
                            end else begin
                                in_cnt_reg <= '0;
                            end
                        end
                        ST_CONVERGED: begin
                            if (!in_band) begin
                                out_cnt_reg <= out_cnt_next;
                                if (out_cnt_next == REARM_LIMIT) begin
                                    state_reg  <= ST_ADAPT;
                                    in_cnt_reg <= '0;
                                end
                            end else begin
                                out_cnt_reg <= '0;
                            end
                        end
                        default: begin
                            state_reg <= ST_ADAPT;
                        end
                    endcase
                end
            end

            assign error_out[gi*WIDTH +: WIDTH] = error_reg;
            assign converged_out[gi]            = (state_reg == ST_CONVERGED);
        end
    endgenerate

endmodule

// File: tb/tb_error_calculator_mc.sv
// ============================================================================
// tb_error_calculator_mc
// ----------------------------------------------------------------------------
// Directed-vector bench for error_calculator_mc (WIDTH=16, NUM_CH=2,
// THRESH=10, CONV_COUNT=4, REARM_COUNT=2). Each strobe pushes its
// hand-computed expected errors and convergence flags into a queue; an
// independent monitor pops and compares whenever done_out is seen, and
// checks that error_out holds between strobes.
// ============================================================================
module tb_error_calculator_mc;

    localparam int WIDTH  = 16;
    localparam int NUM_CH = 2;

    logic                    clk_in;
    logic                    rst_in;
    logic [NUM_CH*WIDTH-1:0] feedback_in;
    logic                    error_ready;
    logic                    nc_on;
    logic [3:0]              gain_shift_in;
    logic [NUM_CH*WIDTH-1:0] error_out;
    logic                    done_out;
    logic [NUM_CH-1:0]       converged_out;

    error_calculator_mc #(
        .WIDTH       (WIDTH),
        .NUM_CH      (NUM_CH),
        .THRESH      (10),
        .CONV_COUNT  (4),
        .REARM_COUNT (2)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .feedback_in   (feedback_in),
        .error_ready   (error_ready),
        .nc_on         (nc_on),
        .gain_shift_in (gain_shift_in),
        .error_out     (error_out),
        .done_out      (done_out),
        .converged_out (converged_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [NUM_CH*WIDTH-1:0] err;
        logic [NUM_CH-1:0]       conv;
    } exp_t;

    exp_t                    exp_q[$];
    int                      checks    = 0;
    int                      failures  = 0;
    int                      n_strobes = 0;
    int                      n_done    = 0;
    int                      txn       = 0;
    logic [NUM_CH*WIDTH-1:0] held_err  = '0;

    // ------------------------------------------------------------------------
    // Stimulus: one strobe cycle followed by one idle cycle.
    // ------------------------------------------------------------------------
    task automatic strobe(input int f0, input int f1, input logic nc,
                          input logic [3:0] sh, input int e0, input int e1,
                          input logic [1:0] cv);
        exp_t e;
        @(negedge clk_in);
        feedback_in   = {WIDTH'(f1), WIDTH'(f0)};
        nc_on         = nc;
        gain_shift_in = sh;
        error_ready   = 1'b1;
        e.err  = {WIDTH'(e1), WIDTH'(e0)};
        e.conv = cv;
        exp_q.push_back(e);
        n_strobes++;
        @(negedge clk_in);
        error_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (error_out !== '0 || done_out !== 1'b0 || converged_out !== '0) begin
            failures++;
            $display("FAIL %s: error_out=%h done_out=%b converged_out=%b, required 0/0/0",
                     name, error_out, done_out, converged_out);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    always @(negedge clk_in) begin
        if (rst_in) begin
            held_err = '0;
        end else if (done_out) begin
            n_done++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: done_out=1 with no strobe pending, required 0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: err0=%0d err1=%0d conv=%b (exp err0=%0d err1=%0d conv=%b)",
                         txn, $signed(error_out[WIDTH-1:0]), $signed(error_out[2*WIDTH-1:WIDTH]),
                         converged_out, $signed(e.err[WIDTH-1:0]),
                         $signed(e.err[2*WIDTH-1:WIDTH]), e.conv);
                if (error_out !== e.err) begin
                    failures++;
                    $display("FAIL txn%0d_error: actual=%h required=%h", txn, error_out, e.err);
                end
                checks++;
                if (converged_out !== e.conv) begin
                    failures++;
                    $display("FAIL txn%0d_converged: actual=%b required=%b", txn, converged_out, e.conv);
                end
                held_err = e.err;
            end
        end else begin
            checks++;
            if (error_out !== held_err) begin
                failures++;
                $display("FAIL error_hold: actual=%h required=%h", error_out, held_err);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_in        = 1'b1;
        feedback_in   = '0;
        error_ready   = 1'b0;
        nc_on         = 1'b0;
        gain_shift_in = '0;
        #12;
        check_reset_state("reset_state");
        @(negedge clk_in);
        rst_in = 1'b0;

        // T1: latency
        strobe(100, 200, 1'b1, 4'd0, -100, -200, 2'b00);

        // T2: converge on 4th in-band sample, then error gated
        strobe(5, 200, 1'b1, 4'd0, -5, -200, 2'b00);
        strobe(5, 200, 1'b1, 4'd0, -5, -200, 2'b00);
        strobe(5, 200, 1'b1, 4'd0, -5, -200, 2'b00);
        strobe(5, 200, 1'b1, 4'd0, -5, -200, 2'b01);
        strobe(5, 200, 1'b1, 4'd0,  0, -200, 2'b01);

        // T3: hysteresis
        strobe(50, 200, 1'b1, 4'd0,   0, -200, 2'b01);
        strobe( 3, 200, 1'b1, 4'd0,   0, -200, 2'b01);
        strobe(50, 200, 1'b1, 4'd0,   0, -200, 2'b01);
        strobe(50, 200, 1'b1, 4'd0,   0, -200, 2'b00);
        strobe(50, 200, 1'b1, 4'd0, -50, -200, 2'b00);

        // T4: band edges reset in_cnt; +/-9 are in band; saturation
        strobe(  5, 200, 1'b1, 4'd0,  -5, -200, 2'b00);
        strobe(  5, 200, 1'b1, 4'd0,  -5, -200, 2'b00);
        strobe(  5, 200, 1'b1, 4'd0,  -5, -200, 2'b00);
        strobe( 10, 200, 1'b1, 4'd0, -10, -200, 2'b00);
        strobe(  5, 200, 1'b1, 4'd0,  -5, -200, 2'b00);
        strobe(  5, 200, 1'b1, 4'd0,  -5, -200, 2'b00);
        strobe(  5, 200, 1'b1, 4'd0,  -5, -200, 2'b00);
        strobe(-10, 200, 1'b1, 4'd0,  10, -200, 2'b00);
        strobe( -9, 200, 1'b1, 4'd0,   9, -200, 2'b00);
        strobe(  9, 200, 1'b1, 4'd0,  -9, -200, 2'b00);
        strobe(  9, 200, 1'b1, 4'd0,  -9, -200, 2'b00);
        strobe( -9, 200, 1'b1, 4'd0,   9, -200, 2'b01);
        strobe( 50, 200, 1'b1, 4'd0,   0, -200, 2'b01);
        strobe( 50, 200, 1'b1, 4'd0,   0, -200, 2'b00);
        strobe(-32768, 32767, 1'b1, 4'd0, 32767, -32767, 2'b00);

        // T5: nc_on gates error only; channels independent
        strobe( 5, 200, 1'b0, 4'd0,   0,    0, 2'b00);
        strobe( 5, 200, 1'b0, 4'd0,   0,    0, 2'b00);
        strobe( 5, 200, 1'b0, 4'd0,   0,    0, 2'b00);
        strobe( 5, 200, 1'b0, 4'd0,   0,    0, 2'b01);
        strobe( 5, 200, 1'b1, 4'd0,   0, -200, 2'b01);
        strobe(50,  -3, 1'b1, 4'd0,   0,    3, 2'b01);
        strobe(50,  -3, 1'b1, 4'd0,   0,    3, 2'b00);
        strobe(50,  -3, 1'b1, 4'd0, -50,    3, 2'b00);
        strobe(50,  -3, 1'b1, 4'd0, -50,    3, 2'b10);

        // Mid-operation reset clears state and partial counts
        strobe(5, -3, 1'b1, 4'd0, -5, 0, 2'b10);
        strobe(5, -3, 1'b1, 4'd0, -5, 0, 2'b10);
        strobe(5, -3, 1'b1, 4'd0, -5, 0, 2'b10);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check_reset_state("mid_reset_state");
        @(negedge clk_in);
        rst_in = 1'b0;
        strobe(5, -3, 1'b1, 4'd0, -5, 3, 2'b00);

`ifdef ERROR_GAIN_EN
        // T6: arithmetic gain shift
        strobe(100, 200, 1'b1, 4'd2,  -25, -50, 2'b00);
        strobe( -7, 200, 1'b1, 4'd2,    1, -50, 2'b00);
        strobe(100, 200, 1'b1, 4'd15,  -1,  -1, 2'b00);
`else
        // gain_shift_in has no effect in this build
        strobe(100, 200, 1'b1, 4'd3, -100, -200, 2'b00);
        strobe( -7, 200, 1'b1, 4'd15,   7, -200, 2'b00);
`endif

        // Drain with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_in);
        repeat (3) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
        end
        checks++;
        if (n_done != n_strobes) begin
            failures++;
            $display("FAIL done_pulse_count: actual=%0d required=%0d", n_done, n_strobes);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
